// File: rtl/instruction_decode_stage.sv
// MIPS-subset decode stage: register file with write bypass, control decode,
// immediate/target generation and an ID/EX register with stall/flush/valid.
module instruction_decode_stage #(
  parameter int unsigned REG_COUNT    = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IR,
  input  logic [31:0] PC_plus4,
  input  logic        stall,
  input  logic        flush,
  input  logic        WB_enable,
  input  logic [4:0]  WB_reg,
  input  logic [31:0] WB_data,
  output logic [31:0] RS_data,
  output logic [31:0] RT_data,
  output logic [31:0] IMM_ext,
  output logic [4:0]  DEST_reg,
  output logic [2:0]  ALU_op,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        ALUSrc,
  output logic        Branch,
  output logic        Jump,
  output logic [31:0] branch_target,
  output logic [31:0] jump_target,
  output logic        valid,
  output logic        illegal
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic [DATA_W-1:0] regs [REG_COUNT];

  logic [5:0]        opcode, funct;
  logic [ADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0] rs_val, rt_val, imm_val, br_tgt, jmp_tgt;
  logic              wb_active;

  logic              dec_ok, c_reg_write, c_mem_read, c_mem_write, c_mem_to_reg;
  logic              c_alu_src, c_branch, c_jump;
  logic [2:0]        c_alu_op;
  logic [ADDR_W-1:0] c_dest;

  assign opcode    = IR[31:26];
  assign rs        = IR[25:21];
  assign rt        = IR[20:16];
  assign rd        = IR[15:11];
  assign funct     = IR[5:0];
  assign wb_active = WB_enable && (WB_reg != '0) && (32'(WB_reg) < REG_COUNT);

  assign imm_val = {{16{IR[15]}}, IR[15:0]};
  assign br_tgt  = PC_plus4 + {imm_val[DATA_W-3:0], 2'b00};
  assign jmp_tgt = {PC_plus4[31:28], IR[25:0], 2'b00};

  // Operand read; a same-cycle writeback to the addressed register wins.
  always_comb begin
    rs_val = '0;
    rt_val = '0;
    if (wb_active && (WB_reg == rs))          rs_val = WB_data;
    else if (rs != '0 && 32'(rs) < REG_COUNT) rs_val = regs[rs];
    if (wb_active && (WB_reg == rt))          rt_val = WB_data;
    else if (rt != '0 && 32'(rt) < REG_COUNT) rt_val = regs[rt];
  end

  // Control decode; the all-zero word is a NOP with every control low.
  always_comb begin
    dec_ok       = 1'b1;
    c_reg_write  = 1'b0;
    c_mem_read   = 1'b0;
    c_mem_write  = 1'b0;
    c_mem_to_reg = 1'b0;
    c_alu_src    = 1'b0;
    c_branch     = 1'b0;
    c_jump       = 1'b0;
    c_alu_op     = 3'b000;
    c_dest       = '0;
    if (IR != '0) begin
      case (opcode)
        6'h00: begin
          c_reg_write = 1'b1;
          c_dest      = rd;
          case (funct)
            6'h20:   c_alu_op = 3'b010;
            6'h22:   c_alu_op = 3'b110;
            6'h24:   c_alu_op = 3'b000;
            6'h25:   c_alu_op = 3'b001;
            6'h2a:   c_alu_op = 3'b111;
            default: dec_ok   = 1'b0;
          endcase
        end
        6'h23: begin
          c_alu_op     = 3'b010;
          c_alu_src    = 1'b1;
          c_mem_read   = 1'b1;
          c_mem_to_reg = 1'b1;
          c_reg_write  = 1'b1;
          c_dest       = rt;
        end
        6'h2b: begin
          c_alu_op    = 3'b010;
          c_alu_src   = 1'b1;
          c_mem_write = 1'b1;
        end
        6'h04: begin
          c_alu_op = 3'b110;
          c_branch = 1'b1;
        end
        6'h02:   c_jump = 1'b1;
        default: dec_ok = 1'b0;
      endcase
    end
  end

  // Register file and ID/EX register. Flush and bubbles load all-zero fields.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < int'(REG_COUNT); i++) regs[i] <= '0;
      RS_data       <= '0;
      RT_data       <= '0;
      IMM_ext       <= '0;
      DEST_reg      <= '0;
      ALU_op        <= '0;
      RegWrite      <= 1'b0;
      MemRead       <= 1'b0;
      MemWrite      <= 1'b0;
      MemToReg      <= 1'b0;
      ALUSrc        <= 1'b0;
      Branch        <= 1'b0;
      Jump          <= 1'b0;
      branch_target <= RESET_VECTOR;
      jump_target   <= RESET_VECTOR;
      valid         <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      if (wb_active) regs[WB_reg] <= WB_data;
      if (flush || (!stall && !dec_ok)) begin
        RS_data       <= '0;
        RT_data       <= '0;
        IMM_ext       <= '0;
        DEST_reg      <= '0;
        ALU_op        <= '0;
        RegWrite      <= 1'b0;
        MemRead       <= 1'b0;
        MemWrite      <= 1'b0;
        MemToReg      <= 1'b0;
        ALUSrc        <= 1'b0;
        Branch        <= 1'b0;
        Jump          <= 1'b0;
        branch_target <= '0;
        jump_target   <= '0;
        valid         <= 1'b0;
        illegal       <= !flush;
      end else if (!stall) begin
        RS_data       <= rs_val;
        RT_data       <= rt_val;
        IMM_ext       <= imm_val;
        DEST_reg      <= c_dest;
        ALU_op        <= c_alu_op;
        RegWrite      <= c_reg_write;
        MemRead       <= c_mem_read;
        MemWrite      <= c_mem_write;
        MemToReg      <= c_mem_to_reg;
        ALUSrc        <= c_alu_src;
        Branch        <= c_branch;
        Jump          <= c_jump;
        branch_target <= br_tgt;
        jump_target   <= jmp_tgt;
        valid         <= 1'b1;
        illegal       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Scoreboard bench for instruction_decode_stage: a reference model predicts the
// ID/EX contents for each driven cycle and the prediction is compared after posedge.
module tb_instruction_decode_stage;

  localparam logic [31:0] RV = 32'h0000_1000;

  logic        CLK = 1'b0;
  logic        RESET, stall, flush, WB_enable;
  logic [31:0] IR, PC_plus4, WB_data;
  logic [4:0]  WB_reg;
  logic [31:0] RS_data, RT_data, IMM_ext, branch_target, jump_target;
  logic [4:0]  DEST_reg;
  logic [2:0]  ALU_op;
  logic        RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, Jump, valid, illegal;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rs, rt, imm;
    logic [4:0]  dest;
    logic [2:0]  alu;
    logic        rw, mr, mw, m2r, src, br, jp;
    logic [31:0] bt, jt;
    logic        v, ill;
  } exp_t;

  exp_t        sb[$];
  exp_t        last;
  logic [31:0] ref_regs [32];

  instruction_decode_stage #(.REG_COUNT(32), .RESET_VECTOR(RV)) dut (
    .CLK(CLK), .RESET(RESET), .IR(IR), .PC_plus4(PC_plus4), .stall(stall), .flush(flush),
    .WB_enable(WB_enable), .WB_reg(WB_reg), .WB_data(WB_data),
    .RS_data(RS_data), .RT_data(RT_data), .IMM_ext(IMM_ext), .DEST_reg(DEST_reg), .ALU_op(ALU_op),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .ALUSrc(ALUSrc), .Branch(Branch), .Jump(Jump),
    .branch_target(branch_target), .jump_target(jump_target), .valid(valid), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (WB_enable && WB_reg == a) return WB_data;
    return ref_regs[a];
  endfunction

  function automatic exp_t model(input exp_t prev);
    exp_t e;
    logic ok;
    e = '0;
    if (RESET) begin
      e.bt = RV;
      e.jt = RV;
      return e;
    end
    if (flush) return e;
    if (stall) return prev;
    e.rs  = rd_model(IR[25:21]);
    e.rt  = rd_model(IR[20:16]);
    e.imm = {{16{IR[15]}}, IR[15:0]};
    e.bt  = PC_plus4 + (e.imm << 2);
    e.jt  = {PC_plus4[31:28], IR[25:0], 2'b00};
    e.v   = 1'b1;
    ok    = 1'b1;
    if (IR != 32'h0) begin
      unique case (IR[31:26])
        6'h00: begin
          e.rw = 1'b1; e.dest = IR[15:11];
          if      (IR[5:0] == 6'h20) e.alu = 3'b010;
          else if (IR[5:0] == 6'h22) e.alu = 3'b110;
          else if (IR[5:0] == 6'h24) e.alu = 3'b000;
          else if (IR[5:0] == 6'h25) e.alu = 3'b001;
          else if (IR[5:0] == 6'h2a) e.alu = 3'b111;
          else ok = 1'b0;
        end
        6'h23: begin e.alu = 3'b010; e.src = 1; e.mr = 1; e.m2r = 1; e.rw = 1; e.dest = IR[20:16]; end
        6'h2b: begin e.alu = 3'b010; e.src = 1; e.mw = 1; end
        6'h04: begin e.alu = 3'b110; e.br = 1; end
        6'h02: e.jp = 1'b1;
        default: ok = 1'b0;
      endcase
    end
    if (!ok) begin
      e = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic compare(input exp_t e);
    check("RS_data", RS_data, e.rs);
    check("RT_data", RT_data, e.rt);
    check("IMM_ext", IMM_ext, e.imm);
    check("DEST_reg", 32'(DEST_reg), 32'(e.dest));
    check("ALU_op", 32'(ALU_op), 32'(e.alu));
    check("ctrl", 32'({RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, Jump}),
          32'({e.rw, e.mr, e.mw, e.m2r, e.src, e.br, e.jp}));
    check("branch_target", branch_target, e.bt);
    check("jump_target", jump_target, e.jt);
    check("valid", 32'(valid), 32'(e.v));
    check("illegal", 32'(illegal), 32'(e.ill));
  endtask

  // One clock: predict, push, advance, then pop and compare.
  task automatic step();
    exp_t e;
    e    = model(last);
    last = e;
    sb.push_back(e);
    if (RESET) begin
      for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
    end else if (WB_enable && WB_reg != 5'd0) begin
      ref_regs[WB_reg] = WB_data;
    end
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard empty");
    end else begin
      compare(sb.pop_front());
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] d, s, t, input logic [5:0] fn);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, t,
                                        input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    WB_enable = en; WB_reg = r; WB_data = d;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns [5];
    logic [4:0] s, t, d;
    int         k;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    s = 5'($urandom); t = 5'($urandom); d = 5'($urandom);
    k = int'($urandom_range(0, 9));
    case (k)
      0, 1, 2: return rtype(d, s, t, fns[$urandom_range(0, 4)]);
      3:       return itype(6'h23, s, t, 16'($urandom));
      4:       return itype(6'h2b, s, t, 16'($urandom));
      5:       return itype(6'h04, s, t, 16'($urandom));
      6:       return {6'h02, 26'($urandom)};
      7:       return rtype(d, s, t, 6'h3f);
      8:       return itype(6'h3f, s, t, 16'($urandom));
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    last = '0;
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
    RESET = 1'b1; stall = 1'b0; flush = 1'b0;
    IR = 32'h0; PC_plus4 = 32'h0000_0004;
    wb(1'b0, 5'd0, 32'h0);

    // Reset for two cycles, then dirty the register file and reset again.
    repeat (2) step();
    RESET = 1'b0;
    for (int i = 1; i < 32; i++) begin
      wb(1'b1, 5'(i), $urandom);
      step();
    end
    wb(1'b0, 5'd0, 32'h0);
    RESET = 1'b1;
    IR = rtype(5'd1, 5'd3, 5'd4, 6'h20);
    repeat (2) step();
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_bt", branch_target, RV);
    RESET = 1'b0;

    // Write r5=7 and sweep every register back out through R-type reads.
    wb(1'b1, 5'd5, 32'd7);
    IR = 32'h0;
    step();
    wb(1'b0, 5'd0, 32'h0);
    IR = rtype(5'd1, 5'd5, 5'd0, 6'h20);
    step();
    check("r5_readback", RS_data, 32'd7);
    for (int i = 0; i < 32; i += 2) begin
      IR = rtype(5'd9, 5'(i), 5'(i + 1), 6'h25);
      step();
    end

    // Same-cycle write bypass.
    wb(1'b1, 5'd2, 32'd339);
    IR = rtype(5'd4, 5'd2, 5'd3, 6'h20);
    step();
    check("bypass_rs", RS_data, 32'd339);
    check("bypass_dest", 32'(DEST_reg), 32'd4);

    // Writes to r0 are dropped, including from the bypass path.
    wb(1'b1, 5'd0, 32'hFFFF);
    IR = rtype(5'd6, 5'd0, 5'd2, 6'h22);
    step();
    wb(1'b0, 5'd0, 32'h0);
    step();
    check("r0_zero", RS_data, 32'h0);

    // Branch and jump targets.
    PC_plus4 = 32'h40;
    IR = itype(6'h04, 5'd2, 5'd3, 16'hFFFE);
    step();
    check("beq_target", branch_target, 32'h38);
    check("beq_imm", IMM_ext, 32'hFFFF_FFFE);
    PC_plus4 = 32'h5C;
    IR = {6'h02, 26'd5};
    step();
    check("j_target", jump_target, 32'h14);

    // lw, then a three-cycle stall with a write to the held rs register.
    PC_plus4 = 32'h60;
    IR = itype(6'h23, 5'd2, 5'd7, 16'd8);
    step();
    stall = 1'b1;
    IR = rtype(5'd8, 5'd2, 5'd2, 6'h2a);
    wb(1'b1, 5'd2, 32'hDEAD_BEEF);
    repeat (3) step();
    check("stall_hold_rs", RS_data, 32'd339);
    wb(1'b0, 5'd0, 32'h0);
    flush = 1'b1;
    step();
    check("flush_valid", 32'(valid), 32'h0);
    stall = 1'b0; flush = 1'b0;

    // Illegal opcode, a second illegal, then recovery; also an unsupported funct.
    IR = itype(6'h3f, 5'd1, 5'd2, 16'h1234);
    step();
    check("illegal_set", 32'(illegal), 32'h1);
    IR = rtype(5'd3, 5'd1, 5'd2, 6'h00);
    step();
    IR = itype(6'h2b, 5'd2, 5'd9, 16'h8000);
    step();
    check("illegal_clear", 32'(illegal), 32'h0);

    // Randomised traffic with writebacks, stalls and flushes.
    for (int n = 0; n < 200; n++) begin
      IR       = rand_instr();
      PC_plus4 = {$urandom} & 32'hFFFF_FFFC;
      wb(1'($urandom_range(0, 1)), 5'($urandom), $urandom);
      stall    = ($urandom_range(0, 5) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode_stage.md
# instruction_decode_stage

Decode stage that sits directly downstream of the instruction fetch block. It consumes the fetched instruction register and the PC+4 value, holds the 32 x 32-bit general register file, and decodes the supported MIPS subset into control signals. It computes the sign-extended immediate and the branch/jump targets, then registers everything into an ID/EX pipeline register with stall, flush and valid control. Supported subset: add, sub, and, or, slt, lw, sw, beq, j.

## Interface
Parameters:
- REG_COUNT, 32, number of general registers; register 0 reads as zero.
- RESET_VECTOR, 32'h00000000, value loaded into `branch_target` and `jump_target` on reset.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- IR  in  32  fetched instruction; stable across posedge because fetch latches it on negedge.
- PC_plus4  in  32  PC+4 from the fetch adder.
- stall  in  1  hold the ID/EX register contents.
- flush  in  1  load a bubble into ID/EX.
- WB_enable  in  1  register-file write enable from writeback.
- WB_reg  in  5  write address.
- WB_data  in  32  write data.
- RS_data, RT_data  out  32  operand values (registered).
- IMM_ext  out  32  sign-extended imm16 (registered).
- DEST_reg  out  5  destination register (registered).
- ALU_op  out  3  encoding: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, Jump  out  1 each  control signals (registered).
- branch_target, jump_target  out  32  computed targets (registered).
- valid  out  1  ID/EX holds a real instruction.
- illegal  out  1  the instruction just decoded was unsupported.

## Operation
- Register file: write on posedge when `WB_enable` is 1 and `WB_reg` != 0. Writes to r0 are ignored. Writes proceed regardless of `stall` or `flush`.
- Read bypass: if `WB_enable` is 1, `WB_reg` != 0, and `WB_reg` equals rs (or rt), the read returns `WB_data` in the same cycle.
- R-type (opcode 0):
  - funct 20/22/24/25/2a map to ADD/SUB/AND/OR/SLT.
  - `RegWrite`=1, `DEST_reg`=rd, `ALUSrc`=0.
- lw (opcode 23): ADD, `ALUSrc`=1, `MemRead`=1, `MemToReg`=1, `RegWrite`=1, `DEST_reg`=rt.
- sw (opcode 2b): ADD, `ALUSrc`=1, `MemWrite`=1, `DEST_reg`=0.
- beq (opcode 4): SUB, `Branch`=1, `branch_target` = `PC_plus4` + (`IMM_ext` << 2), computed in 32-bit arithmetic with wrap-around.
- j (opcode 2): `Jump`=1, `jump_target` = {`PC_plus4`[31:28], IR[25:0], 2'b00}.
- `IR` == 32'h0 is a NOP: `valid`=1, all control signals 0, `illegal`=0.
- Any other opcode, or an R-type funct outside the supported set, produces a bubble with `illegal`=1.
- `IMM_ext` = {16{IR[15]}, IR[15:0]} for every instruction.

## Timing
- Latency is 1 cycle: `IR` sampled at posedge N appears on the outputs after posedge N.
- Priority per posedge: RESET > flush > stall > normal load.
- RESET:
  - All 32 registers cleared.
  - All outputs 0, including `valid`=0 and `illegal`=0.
  - Both targets = RESET_VECTOR.
  - Any in-flight decode is discarded.
- flush: all control signals, `valid` and `illegal` forced to 0. Data and target fields are don't-care but are loaded as 0.
- stall (without flush): every ID/EX field holds its value. The register-file write still occurs, but held `RS_data`/`RT_data` are not refreshed.
- Bubble (illegal instruction): same as flush except `illegal`=1. `illegal` stays high for exactly one cycle unless the next instruction is also illegal.
- Simultaneous write and read of the same register: the bypass returns the new value.

## Test plan
- Reset: assert RESET for 2 cycles, then write r5=7 and read it back through an R-type → every output 0 during reset; after reset r0..r31 read 0 apart from the new write.
- Write/bypass: `WB_enable`=1, `WB_reg`=2, `WB_data`=339 in the same cycle as `IR`=add r4,r2,r3 (r3=0) → `RS_data`=339, `ALU_op`=010, `DEST_reg`=4, `RegWrite`=1.
- Writes to r0: write r0=0xFFFF, then decode an instruction reading rs=0 → `RS_data`=0.
- Branch target: `PC_plus4`=0x40, `IR`=beq r2,r3,-2 (imm 0xFFFE) → `branch_target`=0x38, `IMM_ext`=0xFFFFFFFE, `Branch`=1, `ALU_op`=110.
- Jump: `PC_plus4`=0x5C, `IR`={6'h2,26'd5} → `jump_target`=0x14, `Jump`=1, `RegWrite`=0.
- Stall, flush and illegal, in sequence:
  - Load lw, then assert stall for 3 cycles → outputs unchanged.
  - Assert stall+flush together → `valid`=0.
  - Decode `IR` opcode 3F → `illegal`=1 for one cycle, all control signals 0.
